// File: rtl/fp_exp_pkg.sv
// Shared exponent-path constants and the single-precision result record
// for the FP add/sub exponent-alignment stage.
package fp_exp_pkg;

   localparam int EXP_W_SP     = 8;
   localparam int EXP_W_DP     = 11;
   localparam int MAX_SHIFT_SP = 27;
   localparam int MAX_SHIFT_DP = 56;
   localparam int SHIFT_W_SP   = 5;

   typedef struct packed {
      logic [EXP_W_SP:0]   diff;
      logic [EXP_W_SP-1:0] exp_max;
      logic                swap;
      logic [SHIFT_W_SP-1:0] shift;
      logic                sat;
      logic                eq;
   } exp_res_t;

endpackage

// File: rtl/exp_cla_sub.sv
// Computes a + ~b + ci using 4-bit carry-lookahead groups.
// The groups are chained by ripple, and the final carry is exposed as co.
module exp_cla_sub #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            ci,
   output logic [SIZE-1:0] d,
   output logic            co
);

   localparam int NG = (SIZE + 3) / 4;

   logic [SIZE-1:0] g;
   logic [SIZE-1:0] p;

   assign g = a & ~b;
   assign p = a ^ ~b;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int BASE = gi * 4;
      localparam int GW   = (SIZE - BASE < 4) ? (SIZE - BASE) : 4;

      logic [GW-1:0] gg;
      logic [GW-1:0] pp;
      logic [GW:0]   cc;
      logic          gci;
      logic          gco;

      if (gi == 0) begin : g_first
         assign gci = ci;
      end else begin : g_next
         assign gci = g_grp[gi-1].gco;
      end

      assign gg = g[BASE +: GW];
      assign pp = p[BASE +: GW];

      // Each carry is formed from the group inputs and the group carry-in only.
      always_comb begin
         logic carry;
         logic term;
         cc    = '0;
         cc[0] = gci;
         for (int k = 0; k < GW; k++) begin
            carry = gci;
            for (int j = 0; j <= k; j++) carry = carry & pp[j];
            for (int j = 0; j <= k; j++) begin
               term = gg[j];
               for (int m = j + 1; m <= k; m++) term = term & pp[m];
               carry = carry | term;
            end
            cc[k+1] = carry;
         end
      end

      assign d[BASE +: GW] = pp ^ cc[GW-1:0];
      assign gco           = cc[GW];
   end

   assign co = g_grp[NG-1].gco;

endmodule

// File: rtl/exp_align_sub.sv
// Two-stage exponent-difference unit. It produces max exponent, swap flag,
// absolute or signed difference, and the saturated alignment shift.
module exp_align_sub
   import fp_exp_pkg::*;
#(
   parameter int SIZE_EXP   = EXP_W_SP,
   parameter int SIZE_SHIFT = SHIFT_W_SP,
   parameter int MAX_SHIFT  = MAX_SHIFT_SP
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_mode,
   input  logic [SIZE_EXP-1:0]   i_data_a,
   input  logic [SIZE_EXP-1:0]   i_data_b,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [SIZE_EXP:0]     o_diff,
   output logic [SIZE_EXP-1:0]   o_exp_max,
   output logic                  o_swap,
   output logic [SIZE_SHIFT-1:0] o_shift,
   output logic                  o_sat,
   output logic                  o_eq
);

   // Handshake: a pair enters on i_valid && o_ready and a result leaves on
   // o_valid && i_ready. The producer must hold its data until that transfer
   // happens. o_ready is combinational from i_ready, and no skid buffer exists.

   typedef struct packed {
      logic [SIZE_EXP:0]     diff;
      logic [SIZE_EXP-1:0]   exp_max;
      logic                  swap;
      logic [SIZE_SHIFT-1:0] shift;
      logic                  sat;
      logic                  eq;
   } res_t;

   localparam logic [SIZE_EXP-1:0]   SAT_LIM   = SIZE_EXP'(MAX_SHIFT);
   localparam logic [SIZE_SHIFT-1:0] SHIFT_LIM = SIZE_SHIFT'(MAX_SHIFT);
   localparam logic [SIZE_EXP-1:0]   ONE_E     = SIZE_EXP'(1);

   logic                s1_valid;
   logic [SIZE_EXP:0]   s1_dab;
   logic [SIZE_EXP-1:0] s1_a;
   logic [SIZE_EXP-1:0] s1_b;
   logic                s1_mode;

   logic                s2_valid;
   res_t                s2_res;
   res_t                s2_next;

   logic                s1_load;
   logic                s2_load;

   logic [SIZE_EXP-1:0] sub_diff;
   logic                sub_nb;

   logic                s2_swap;
   logic [SIZE_EXP-1:0] s2_low;
   logic [SIZE_EXP-1:0] s2_mag;
   logic                s2_sat;

   exp_cla_sub #(
      .SIZE (SIZE_EXP)
   ) u_sub (
      .a  (i_data_a),
      .b  (i_data_b),
      .ci (1'b1),
      .d  (sub_diff),
      .co (sub_nb)
   );

   // A stage reloads when it is empty, or when its contents move forward.
   assign s2_load = ~s2_valid | i_ready;
   assign s1_load = ~s1_valid | s2_load;
   assign o_ready = s1_load;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_dab   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_mode  <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_dab  <= {sub_nb, sub_diff};
            s1_a    <= i_data_a;
            s1_b    <= i_data_b;
            s1_mode <= i_mode;
         end
      end
   end

   // The low bits hold Ea-Eb modulo 2**SIZE_EXP. Negating them recovers |Ea-Eb| on a borrow.
   always_comb begin
      s2_swap         = ~s1_dab[SIZE_EXP];
      s2_low          = s1_dab[SIZE_EXP-1:0];
      s2_mag          = s2_swap ? ((~s2_low) + ONE_E) : s2_low;
      s2_sat          = s2_mag > SAT_LIM;
      s2_next         = '0;
      s2_next.diff    = s1_mode ? {s2_swap, s2_low} : {1'b0, s2_mag};
      s2_next.exp_max = s2_swap ? s1_b : s1_a;
      s2_next.swap    = s2_swap;
      s2_next.shift   = s2_sat ? SHIFT_LIM : s2_mag[SIZE_SHIFT-1:0];
      s2_next.sat     = s2_sat;
      s2_next.eq      = (s2_mag == '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_res   <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_res <= s2_next;
         end
      end
   end

   assign o_valid   = s2_valid;
   assign o_diff    = s2_res.diff;
   assign o_exp_max = s2_res.exp_max;
   assign o_swap    = s2_res.swap;
   assign o_shift   = s2_res.shift;
   assign o_sat     = s2_res.sat;
   assign o_eq      = s2_res.eq;

endmodule

// File: tb/tb_exp_align_sub.sv
// Bench for exp_align_sub: directed vectors at single precision, backpressure,
// and a randomized stream checked against a reference model at both sizes.
module tb_exp_align_sub;
   import fp_exp_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic        sp_valid, sp_o_ready, sp_mode, sp_o_valid, sp_ready;
   logic [7:0]  sp_a, sp_b, sp_emax;
   logic [8:0]  sp_diff;
   logic        sp_swap, sp_sat, sp_eq;
   logic [4:0]  sp_shift;

   logic        dp_valid, dp_o_ready, dp_mode, dp_o_valid, dp_ready;
   logic [10:0] dp_a, dp_b, dp_emax;
   logic [11:0] dp_diff;
   logic        dp_swap, dp_sat, dp_eq;
   logic [5:0]  dp_shift;

   logic [31:0] sp_res, dp_res;
   assign sp_res = {7'b0, sp_diff, sp_emax, sp_swap, sp_shift, sp_sat, sp_eq};
   assign dp_res = {dp_diff, dp_emax, dp_swap, dp_shift, dp_sat, dp_eq};

   exp_align_sub #(.SIZE_EXP(EXP_W_SP), .SIZE_SHIFT(5), .MAX_SHIFT(MAX_SHIFT_SP)) dut_sp (
      .i_clk(clk), .i_rst(rst), .i_valid(sp_valid), .o_ready(sp_o_ready), .i_mode(sp_mode),
      .i_data_a(sp_a), .i_data_b(sp_b), .o_valid(sp_o_valid), .i_ready(sp_ready),
      .o_diff(sp_diff), .o_exp_max(sp_emax), .o_swap(sp_swap), .o_shift(sp_shift),
      .o_sat(sp_sat), .o_eq(sp_eq)
   );

   exp_align_sub #(.SIZE_EXP(EXP_W_DP), .SIZE_SHIFT(6), .MAX_SHIFT(MAX_SHIFT_DP)) dut_dp (
      .i_clk(clk), .i_rst(rst), .i_valid(dp_valid), .o_ready(dp_o_ready), .i_mode(dp_mode),
      .i_data_a(dp_a), .i_data_b(dp_b), .o_valid(dp_o_valid), .i_ready(dp_ready),
      .o_diff(dp_diff), .o_exp_max(dp_emax), .o_swap(dp_swap), .o_shift(dp_shift),
      .o_sat(dp_sat), .o_eq(dp_eq)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] sp_exp_q[$];
   logic [31:0] dp_exp_q[$];
   int sp_out_cnt = 0;
   logic sp_stall = 1'b0, dp_stall = 1'b0;
   logic [31:0] sp_held, dp_held;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: packs {diff, exp_max, swap, shift, sat, eq} from plain integer math.
   function automatic logic [31:0] model(input int se, input int ss, input int mx,
                                         input logic mode, input int a, input int b);
      int d, mag, diff, sh;
      logic [31:0] r;
      d    = a - b;
      mag  = (d < 0) ? -d : d;
      diff = mode ? (d & ((1 << (se + 1)) - 1)) : mag;
      sh   = (mag > mx) ? mx : mag;
      r = 32'(diff);
      r = (r << se) | 32'((b > a) ? b : a);
      r = (r << 1)  | 32'(b > a);
      r = (r << ss) | 32'(sh);
      r = (r << 1)  | 32'(mag > mx);
      r = (r << 1)  | 32'(a == b);
      return r;
   endfunction

   // Scoreboard and stall monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         sp_exp_q.delete();
         dp_exp_q.delete();
         sp_stall = 1'b0;
         dp_stall = 1'b0;
      end else begin
         if (sp_stall) check("sp_hold", sp_res, sp_held);
         if (sp_o_valid && sp_ready) begin
            if (sp_exp_q.size() == 0) check("sp_spurious", 32'(sp_o_valid), 32'd0);
            else begin
               check("sp_order", sp_res, sp_exp_q.pop_front());
               sp_out_cnt++;
            end
         end
         if (sp_valid && sp_o_ready)
            sp_exp_q.push_back(model(8, 5, 27, sp_mode, int'(sp_a), int'(sp_b)));
         sp_stall = sp_o_valid && !sp_ready;
         sp_held  = sp_res;

         if (dp_stall) check("dp_hold", dp_res, dp_held);
         if (dp_o_valid && dp_ready) begin
            if (dp_exp_q.size() == 0) check("dp_spurious", 32'(dp_o_valid), 32'd0);
            else check("dp_order", dp_res, dp_exp_q.pop_front());
         end
         if (dp_valid && dp_o_ready)
            dp_exp_q.push_back(model(11, 6, 56, dp_mode, int'(dp_a), int'(dp_b)));
         dp_stall = dp_o_valid && !dp_ready;
         dp_held  = dp_res;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic dir_sp(input string tag, input logic mode, input logic [7:0] a,
                         input logic [7:0] b, input logic [8:0] diff, input logic [7:0] emax,
                         input logic swap, input logic [4:0] shift, input logic sat,
                         input logic eq);
      sp_valid = 1'b1;
      sp_mode  = mode;
      sp_a     = a;
      sp_b     = b;
      tick();
      sp_valid = 1'b0;
      tick();
      check({tag, ".valid"}, 32'(sp_o_valid), 32'd1);
      check({tag, ".diff"},  32'(sp_diff),    32'(diff));
      check({tag, ".emax"},  32'(sp_emax),    32'(emax));
      check({tag, ".swap"},  32'(sp_swap),    32'(swap));
      check({tag, ".shift"}, 32'(sp_shift),   32'(shift));
      check({tag, ".sat"},   32'(sp_sat),     32'(sat));
      check({tag, ".eq"},    32'(sp_eq),      32'(eq));
   endtask

   task automatic push_sp(input logic mode, input logic [7:0] a, input logic [7:0] b);
      logic acc;
      acc      = 1'b0;
      sp_valid = 1'b1;
      sp_mode  = mode;
      sp_a     = a;
      sp_b     = b;
      for (int t = 0; t < 40 && !acc; t++) begin
         @(negedge clk);
         if (sp_o_ready) acc = 1'b1;
         tick();
      end
      sp_valid = 1'b0;
      check("push_accept", 32'(acc), 32'd1);
   endtask

   initial begin
      logic saw_low;
      logic sp_fire, dp_fire;
      int   cnt0;

      rst = 1'b1;
      sp_valid = 1'b1; sp_mode = 1'b0; sp_a = 8'h55; sp_b = 8'h11; sp_ready = 1'b1;
      dp_valid = 1'b1; dp_mode = 1'b1; dp_a = 11'h123; dp_b = 11'h456; dp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_sp_valid", 32'(sp_o_valid), 32'd0);
         check("rst_sp_data",  sp_res, 32'd0);
         check("rst_dp_valid", 32'(dp_o_valid), 32'd0);
         check("rst_dp_data",  dp_res, 32'd0);
      end
      rst = 1'b0;
      sp_valid = 1'b0;
      dp_valid = 1'b0;
      @(negedge clk);
      check("rst_sp_ready", 32'(sp_o_ready), 32'd1);
      check("rst_dp_ready", 32'(dp_o_ready), 32'd1);
      tick();

      dir_sp("a_gt_b", 1'b0, 8'h85, 8'h80, 9'd5,     8'h85, 1'b0, 5'd5,  1'b0, 1'b0);
      dir_sp("swap_m1", 1'b1, 8'h10, 8'h7F, 9'h191,  8'h7F, 1'b1, 5'd27, 1'b1, 1'b0);
      dir_sp("full_rng", 1'b0, 8'hFF, 8'h00, 9'd255, 8'hFF, 1'b0, 5'd27, 1'b1, 1'b0);
      dir_sp("equal",   1'b0, 8'h7F, 8'h7F, 9'd0,    8'h7F, 1'b0, 5'd0,  1'b0, 1'b1);
      dir_sp("neg_max", 1'b1, 8'h00, 8'hFF, 9'h101,  8'hFF, 1'b1, 5'd27, 1'b1, 1'b0);
      dir_sp("at_lim",  1'b0, 8'h20, 8'h3B, 9'd27,   8'h3B, 1'b1, 5'd27, 1'b0, 1'b0);
      dir_sp("over_lim", 1'b1, 8'h3C, 8'h20, 9'h01C, 8'h3C, 1'b0, 5'd27, 1'b1, 1'b0);
      repeat (3) tick();

      cnt0    = sp_out_cnt;
      saw_low = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) push_sp(1'(i % 2), 8'(64 + 9 * i), 8'(68 - 3 * i));
         end
         begin
            repeat (4) tick();
            sp_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (!sp_o_ready) saw_low = 1'b1;
               tick();
            end
            sp_ready = 1'b1;
         end
      join
      check("bp_ready_low", 32'(saw_low), 32'd1);
      repeat (6) tick();
      check("bp_count", 32'(sp_out_cnt - cnt0), 32'd8);

      for (int c = 0; c < 14000; c++) begin
         @(negedge clk);
         sp_fire = sp_valid && sp_o_ready;
         dp_fire = dp_valid && dp_o_ready;
         tick();
         rst = (c >= 7000 && c < 7002);
         if (c == 7002) begin
            check("flush_sp_valid", 32'(sp_o_valid), 32'd0);
            check("flush_dp_valid", 32'(dp_o_valid), 32'd0);
         end
         if (!sp_valid || sp_fire || rst) begin
            sp_valid = ($urandom_range(0, 3) != 0);
            sp_mode  = 1'($urandom_range(0, 1));
            sp_a     = 8'($urandom_range(0, 255));
            sp_b     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                       : 8'(int'(sp_a) + int'($urandom_range(0, 60)) - 30);
         end
         if (!dp_valid || dp_fire || rst) begin
            dp_valid = ($urandom_range(0, 3) != 0);
            dp_mode  = 1'($urandom_range(0, 1));
            dp_a     = 11'($urandom_range(0, 2047));
            dp_b     = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 2047))
                       : 11'(int'(dp_a) + int'($urandom_range(0, 120)) - 60);
         end
         sp_ready = ($urandom_range(0, 3) != 0);
         dp_ready = ($urandom_range(0, 3) != 0);
      end

      rst      = 1'b0;
      sp_valid = 1'b0;
      dp_valid = 1'b0;
      sp_ready = 1'b1;
      dp_ready = 1'b1;
      repeat (8) tick();
      check("sp_drain", 32'(sp_exp_q.size()), 32'd0);
      check("dp_drain", 32'(dp_exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
